// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - multicycle load/store sequencer driving a valid/ready memory port
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        misaligned,
    output logic        bus_error,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   state, state_d;
    logic [2:0]               f3_q, f3_d;
    logic [1:0]               off_q, off_d;
    logic                     st_q, st_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     busy_d, done_d, mis_d, berr_d, valid_d;
    logic [31:0]              result_d, addr_d, wdata_d;
    logic [3:0]               wstrb_d;
    logic                     reject;
    logic [7:0]               byte_sel;
    logic [15:0]              half_sel;
    logic [31:0]              load_val;

    // Reject illegal encodings and misaligned halfword/word accesses up front.
    always_comb begin
        reject = 1'b0;
        if (funct3[1:0] == 2'b11)
            reject = 1'b1;
        else if (funct3[2] && (is_store || funct3[1]))
            reject = 1'b1;
        else if (funct3[1:0] == 2'b01 && addr[0])
            reject = 1'b1;
        else if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            reject = 1'b1;
    end

    always_comb begin
        byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'b0, byte_sel};
            3'b101:  load_val = {16'b0, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state;
        f3_d     = f3_q;
        off_d    = off_q;
        st_d     = st_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        mis_d    = misaligned;
        berr_d   = bus_error;
        result_d = result;
        valid_d  = mem_valid;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        wstrb_d  = mem_wstrb;
        case (state)
            IDLE: begin
                if (start) begin
                    if (reject) begin
                        state_d  = RESP;
                        done_d   = 1'b1;
                        mis_d    = 1'b1;
                        berr_d   = 1'b0;
                        result_d = 32'b0;
                    end else begin
                        state_d = ACCESS;
                        f3_d    = funct3;
                        off_d   = addr[1:0];
                        st_d    = is_store;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        addr_d  = {addr[31:2], 2'b00};
                        if (!is_store) begin
                            wstrb_d = 4'b0000;
                            wdata_d = 32'b0;
                        end else begin
                            case (funct3[1:0])
                                2'b00: begin
                                    wstrb_d = 4'b0001 << addr[1:0];
                                    wdata_d = {4{wdata_in[7:0]}};
                                end
                                2'b01: begin
                                    wstrb_d = 4'b0011 << addr[1:0];
                                    wdata_d = {2{wdata_in[15:0]}};
                                end
                                default: begin
                                    wstrb_d = 4'b1111;
                                    wdata_d = wdata_in;
                                end
                            endcase
                        end
                    end
                end
            end
            ACCESS: begin
                // A ready in the final allowed cycle still completes the access.
                if (mem_ready) begin
                    state_d  = RESP;
                    valid_d  = 1'b0;
                    done_d   = 1'b1;
                    mis_d    = 1'b0;
                    berr_d   = 1'b0;
                    result_d = st_q ? 32'b0 : load_val;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == LIMIT) begin
                    state_d  = RESP;
                    valid_d  = 1'b0;
                    done_d   = 1'b1;
                    mis_d    = 1'b0;
                    berr_d   = 1'b1;
                    result_d = 32'b0;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            f3_q       <= 3'b0;
            off_q      <= 2'b0;
            st_q       <= 1'b0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 32'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            mem_valid  <= 1'b0;
            mem_addr   <= 32'b0;
            mem_wdata  <= 32'b0;
            mem_wstrb  <= 4'b0;
        end else begin
            state      <= state_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            busy       <= busy_d;
            done       <= done_d;
            result     <= result_d;
            misaligned <= mis_d;
            bus_error  <= berr_d;
            mem_valid  <= valid_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            mem_wstrb  <= wstrb_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl with a behavioural access model
module tb_lsu_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        resetn, start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata_in;
    logic        busy, done, misaligned, bus_error, mem_valid, mem_ready;
    logic [31:0] result, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_cmp = 0;
    int n_err = 0;

    lsu_ctrl #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_WIDTH(8)) dut (
        .clk(clk), .resetn(resetn), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata_in(wdata_in), .busy(busy),
        .done(done), .result(result), .misaligned(misaligned),
        .bus_error(bus_error), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Random request while busy; must not disturb anything.
    task automatic junk();
        start    = 1'b1;
        is_store = 1'($urandom);
        funct3   = 3'($urandom);
        addr     = $urandom;
        wdata_in = $urandom;
    endtask

    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits);
        int          size;
        int          k;
        bit          bad;
        bit          fin;
        logic [3:0]  e_strb;
        logic [31:0] e_wd, e_res, v;
        size = 1 << f3[1:0];
        k    = int'(a[1:0]);
        if (st) bad = !(f3 inside {3'd0, 3'd1, 3'd2});
        else    bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!bad && (k % size) != 0) bad = 1;
        e_strb = st ? 4'(((1 << size) - 1) << k) : 4'd0;
        if (size == 1)      e_wd = {24'b0, wd[7:0]} * 32'h01010101;
        else if (size == 2) e_wd = {16'b0, wd[15:0]} * 32'h00010001;
        else                e_wd = wd;
        v = rd >> (8 * k);
        if (size == 1) v = v & 32'hFF;
        if (size == 2) v = v & 32'hFFFF;
        if (!f3[2] && size < 4 && v >= (32'd1 << (8 * size - 1)))
            v = v - (32'd1 << (8 * size));
        e_res = st ? 32'd0 : v;

        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata_in = wd; mem_ready = 1'b0;
        @(negedge clk);
        junk();
        if (bad) begin
            chk("err_done", done, 1);
            chk("err_mis", misaligned, 1);
            chk("err_berr", bus_error, 0);
            chk("err_res", result, 0);
            chk("err_valid", mem_valid, 0);
            chk("err_busy", busy, 1);
            @(negedge clk);
            start = 1'b0;
            chk("err_done_pulse", done, 0);
            chk("err_idle", busy, 0);
            chk("err_mis_hold", misaligned, 1);
            return;
        end
        fin = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            chk("acc_valid", mem_valid, 1);
            chk("acc_busy", busy, 1);
            chk("acc_done", done, 0);
            chk("acc_addr", mem_addr, {a[31:2], 2'b00});
            chk("acc_strb", mem_wstrb, e_strb);
            if (st) chk("acc_wdata", mem_wdata, e_wd);
            mem_ready = (c == waits);
            mem_rdata = (c == waits) ? rd : $urandom;
            junk();
            @(negedge clk);
            mem_ready = 1'b0;
            if (c == waits) begin
                chk("rsp_done", done, 1);
                chk("rsp_res", result, e_res);
                chk("rsp_mis", misaligned, 0);
                chk("rsp_berr", bus_error, 0);
                chk("rsp_valid", mem_valid, 0);
                fin = 1;
            end else if (c == TMO - 1) begin
                chk("tmo_done", done, 1);
                chk("tmo_berr", bus_error, 1);
                chk("tmo_res", result, 0);
                chk("tmo_mis", misaligned, 0);
                chk("tmo_valid", mem_valid, 0);
                fin = 1;
            end
        end
        chk("op_finished", 32'(fin), 1);
        @(negedge clk);
        start = 1'b0;
        chk("post_done_pulse", done, 0);
        chk("post_idle", busy, 0);
        chk("post_res_hold", result, (waits < TMO) ? e_res : 32'd0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata_in = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", mem_valid, 0);
        chk("rst_res", result, 0);
        chk("rst_mis", misaligned, 0);
        chk("rst_berr", bus_error, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_strb", mem_wstrb, 0);
        resetn = 1'b1;

        do_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
        chk("lb_result", result, 32'hFFFFFF80);
        do_op(1'b0, 3'b101, 32'h202, 32'h0, 32'hBEEF1234, 3);
        chk("lhu_result", result, 32'h0000BEEF);
        do_op(1'b1, 3'b000, 32'h301, 32'hA5, 32'h12345678, 0);
        chk("sb_result", result, 32'h0);
        do_op(1'b1, 3'b001, 32'h302, 32'h1234ABCD, 32'h0, 1);
        do_op(1'b0, 3'b010, 32'h401, 32'h0, 32'h0, 0);
        do_op(1'b0, 3'b011, 32'h400, 32'h0, 32'h0, 0);
        do_op(1'b1, 3'b100, 32'h400, 32'h0, 32'h0, 0);
        do_op(1'b0, 3'b010, 32'h600, 32'h0, 32'h55AA55AA, 100);
        chk("tmo_berr_hold", bus_error, 1);
        do_op(1'b0, 3'b010, 32'h604, 32'h0, 32'hCAFEF00D, TMO - 1);
        chk("late_ready_res", result, 32'hCAFEF00D);

        // Reset in the middle of an access.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h500;
        @(negedge clk);
        start = 1'b0;
        chk("mid_valid", mem_valid, 1);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", mem_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("mid_rst_nodone", done, 0);
        chk("mid_rst_idle", busy, 0);
        do_op(1'b0, 3'b010, 32'h700, 32'h0, 32'h13579BDF, 1);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'($urandom_range(0, 1) * 2 * 32'($urandom_range(0, 1)));
            do_op(1'($urandom), 3'($urandom), ra, $urandom, $urandom, $urandom_range(0, 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
